select_buffer: RTL
==================

SELECT_BUFFER -- requirements
Module: select_buffer

Interface
REQ-001 The block SHALL have parameter DATA, default 32, meaning the width of one entry.
REQ-002 The block SHALL have parameter IN, default 4, meaning the number of slots; IN >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-006 The block SHALL have port wr_data, input, DATA bits: write payload.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: high when at least one slot is free.
REQ-008 The block SHALL have port entries, output, DATA*IN bits: slot i contents at bits [DATA*i +: DATA], feeding the selector "in" port.
REQ-009 The block SHALL have port vld_map, output, IN bits: bit i high when slot i holds data, feeding the selector "sel" port in bitmap mode.
REQ-010 The block SHALL have port grant_valid, input, 1 bit: the selector "valid" output.
REQ-011 The block SHALL have port grant_pos, input, IN bits: the selector "pos" output, one-hot.
REQ-012 The block SHALL have port rd_ack, input, 1 bit: the consumer has taken the selector output this cycle.
REQ-013 The block SHALL have port count, output, $clog2(IN+1) bits: the number of occupied slots.
REQ-014 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-015 Slot state SHALL be one valid bit plus one DATA register per slot; vld_map, entries and count SHALL be driven directly from registers.
REQ-016 wr_ready SHALL be high when vld_map is not all ones.
REQ-017 Write acceptance SHALL occur when wr_en=1 and wr_ready=1 in the same cycle.
REQ-018 An accepted write SHALL store wr_data into the lowest-index slot whose valid bit is 0 before this edge, and set that valid bit.
REQ-019 Read release SHALL occur when rd_ack=1 and grant_valid=1 and grant_pos is one-hot and the addressed slot is valid.
REQ-020 A read release SHALL clear the valid bit of the slot addressed by grant_pos; slot data SHALL NOT be cleared.
REQ-021 On simultaneous write and release, both SHALL take effect in the same cycle.
REQ-022 A slot freed in a cycle SHALL NOT be the write target in that same cycle; when full, wr_ready=0 and the write SHALL be refused even if a release occurs.
REQ-023 count SHALL equal the previous count, +1 for an accepted write, -1 for a release, and SHALL always equal popcount(vld_map).
REQ-024 wr_en=1 while wr_ready=0 SHALL drop the write, leave state unchanged and set err.
REQ-025 rd_ack=1 with grant_valid=1 and grant_pos not one-hot, or addressing an empty slot, SHALL release nothing and set err.
REQ-026 rd_ack=1 with grant_valid=0 SHALL be ignored with no error.
REQ-027 err SHALL remain set until reset.
REQ-028 The block SHALL have zero combinational paths from grant_pos, grant_valid or rd_ack to any output; the round trip through the selector is combinational, so a slot is released one cycle after its rd_ack edge.

Reset
REQ-029 While reset is high, vld_map, count and err SHALL be 0, wr_ready SHALL be 1, and entries SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all held data immediately, without waiting for a clock edge.
REQ-031 Writes and releases SHALL NOT take effect on any clock edge during which reset is high.

Verification (DATA=32, IN=4, selector connected in bitmap mode)
REQ-032 Fill scenario: reset, then write 1,2,3,4 on consecutive cycles -> vld_map 0001,0011,0111,1111; count 4; wr_ready 0; entries {4,3,2,1}.
REQ-033 Overflow scenario: write 5 while full -> state unchanged; err=1 from the next cycle and stays 1.
REQ-034 Release scenario: full buffer, grant_pos=0100, grant_valid=1, rd_ack=1 -> vld_map 1011, count 3; next write 9 lands in slot 2.
REQ-035 Simultaneous scenario: vld_map 0011, write 7 plus release of slot 0 in the same cycle -> vld_map 0110, slot 2=7, count 2.
REQ-036 Bad-grant scenario: grant_pos=0101 or 1000 with slot 3 empty, rd_ack=1 -> no release, err=1.
REQ-037 Reset scenario: assert reset asynchronously between edges with count 3 -> vld_map 0000, count 0, err 0 within the same cycle.

Source files
------------

// File: rtl/select_buffer.sv
// Slot buffer feeding a bitmap-mode selector: writes fill the lowest free slot,
// granted reads release the slot named by the selector's one-hot position.
module select_buffer #(
  parameter int DATA = 32,
  parameter int IN   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA-1:0]          wr_data,
  output logic                     wr_ready,
  output logic [DATA*IN-1:0]       entries,
  output logic [IN-1:0]            vld_map,
  input  logic                     grant_valid,
  input  logic [IN-1:0]            grant_pos,
  input  logic                     rd_ack,
  output logic [$clog2(IN+1)-1:0]  count,
  output logic                     err
);

  localparam int CW = $clog2(IN+1);
  localparam logic [IN-1:0] POS_ONE = IN'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [IN-1:0]      vld_q, vld_d;
  logic [DATA*IN-1:0] entries_q, entries_d;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q, err_d;

  logic [IN-1:0] wr_sel;
  logic          found;
  logic          wr_acc, rd_req, rd_acc, pos_onehot;

  assign wr_ready = ~(&vld_q);
  assign vld_map  = vld_q;
  assign entries  = entries_q;
  assign count    = count_q;
  assign err      = err_q;

  always_comb begin
    wr_sel = '0;
    found  = 1'b0;
    // Target is chosen from the pre-edge valid bits, so a slot freed this
    // cycle can never also be written this cycle.
    for (int i = 0; i < IN; i++) begin
      if (!vld_q[i] && !found) begin
        wr_sel[i] = 1'b1;
        found     = 1'b1;
      end
    end

    wr_acc     = wr_en & wr_ready;
    pos_onehot = (grant_pos != '0) && ((grant_pos & (grant_pos - POS_ONE)) == '0);
    rd_req     = rd_ack & grant_valid;
    rd_acc     = rd_req & pos_onehot & (|(grant_pos & vld_q));

    vld_d     = vld_q;
    entries_d = entries_q;
    if (wr_acc) begin
      vld_d = vld_d | wr_sel;
      for (int i = 0; i < IN; i++) begin
        if (wr_sel[i]) entries_d[DATA*i +: DATA] = wr_data;
      end
    end
    if (rd_acc) vld_d = vld_d & ~grant_pos;

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    err_d = err_q | (wr_en & ~wr_ready) | (rd_req & ~rd_acc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      entries_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      entries_q <= entries_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

endmodule
